// File: rtl/pet_core.sv
// rtl/pet_core.sv - virtual pet: debounced buttons, pet state machine, attribute engine
// Attributes decay on game ticks and recover through actions; death holds until rst.
module pet_core #(
  parameter int ATTR_W       = 8,
  parameter int TICK_DIV     = 50000000,
  parameter int DECAY_TICKS  = 4,
  parameter int ACTION_STEP  = 32,
  parameter int ACTION_TICKS = 4,
  parameter int SLEEP_TICKS  = 8,
  parameter int DEBOUNCE_CYC = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              b1,
  input  logic              b2,
  output logic [2:0]        estado,
  output logic [ATTR_W-1:0] fome,
  output logic [ATTR_W-1:0] felicidade,
  output logic [ATTR_W-1:0] sono,
  output logic              morreu,
  output logic              tick
);

  localparam logic [ATTR_W-1:0] MAX = '1;
  localparam int TW      = $clog2(TICK_DIV);
  localparam int DW      = $clog2(DECAY_TICKS + 1);
  localparam int BW      = $clog2(DEBOUNCE_CYC + 1);
  localparam int DUR_MAX = (ACTION_TICKS > SLEEP_TICKS) ? ACTION_TICKS : SLEEP_TICKS;
  localparam int RW      = $clog2(DUR_MAX + 1);

  typedef enum logic [2:0] {
    OCIOSO    = 3'd0,
    COMENDO   = 3'd1,
    BRINCANDO = 3'd2,
    DORMINDO  = 3'd3,
    MORTO     = 3'd4
  } state_t;

  typedef logic signed [ATTR_W+1:0] sw_t;
  localparam sw_t STEP = sw_t'(ACTION_STEP);

  state_t          st;
  logic [TW-1:0]   tcnt;
  logic [DW-1:0]   dcnt;
  logic [RW-1:0]   dur;
  logic [1:0]      raw, sy0, sy1, lvl, ev;
  logic [BW-1:0]   dbc [2];
  logic            decay, dead;
  sw_t             f_sum, h_sum, s_sum;

  assign raw    = {b2, b1};
  assign tick   = (tcnt == TW'(TICK_DIV - 1));
  assign estado = st;
  assign decay  = tick && (dcnt == DW'(DECAY_TICKS - 1));
  assign dead   = (fome == MAX) || (sono == MAX) || (felicidade == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) tcnt <= '0;
    else if (tick) tcnt <= '0;
    else tcnt <= tcnt + 1'b1;
  end

  // Level changes only after DEBOUNCE_CYC consecutive samples disagree with it;
  // the press event fires together with the 0->1 level change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sy0 <= '0;
      sy1 <= '0;
      lvl <= '0;
      ev  <= '0;
      for (int i = 0; i < 2; i++) dbc[i] <= '0;
    end else begin
      sy0 <= raw;
      sy1 <= sy0;
      for (int i = 0; i < 2; i++) begin
        ev[i] <= 1'b0;
        if (sy1[i] == lvl[i]) begin
          dbc[i] <= '0;
        end else if (dbc[i] == BW'(DEBOUNCE_CYC - 1)) begin
          lvl[i] <= sy1[i];
          ev[i]  <= sy1[i];
          dbc[i] <= '0;
        end else begin
          dbc[i] <= dbc[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    f_sum = sw_t'(fome) + sw_t'(decay) - ((st == COMENDO) ? STEP : sw_t'(0));
    h_sum = sw_t'(felicidade) - sw_t'(decay) + ((st == BRINCANDO) ? STEP : sw_t'(0));
    s_sum = sw_t'(sono) + sw_t'(decay) + sw_t'(st == BRINCANDO)
            - ((st == DORMINDO) ? STEP : sw_t'(0));
  end

  function automatic logic [ATTR_W-1:0] sat(input sw_t v);
    if (v < 0) return '0;
    else if (v > sw_t'(MAX)) return MAX;
    else return v[ATTR_W-1:0];
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st         <= OCIOSO;
      fome       <= '0;
      felicidade <= MAX;
      sono       <= '0;
      morreu     <= 1'b0;
      dcnt       <= '0;
      dur        <= '0;
    end else begin
      if (tick) begin
        dcnt <= (dcnt == DW'(DECAY_TICKS - 1)) ? '0 : dcnt + 1'b1;
        if (st != MORTO) begin
          fome       <= sat(f_sum);
          felicidade <= sat(h_sum);
          sono       <= sat(s_sum);
        end
      end
      morreu <= 1'b0;
      if (st == MORTO || dead) begin
        st     <= MORTO;
        morreu <= 1'b1;
      end else begin
        case (st)
          OCIOSO: begin
            if (ev[0] && ev[1]) begin
              st  <= DORMINDO;
              dur <= RW'(SLEEP_TICKS);
            end else if (ev[0]) begin
              st  <= COMENDO;
              dur <= RW'(ACTION_TICKS);
            end else if (ev[1]) begin
              st  <= BRINCANDO;
              dur <= RW'(ACTION_TICKS);
            end
          end
          default: begin
            if (tick) begin
              if (dur == RW'(1)) st <= OCIOSO;
              dur <= dur - 1'b1;
            end
          end
        endcase
      end
    end
  end

endmodule
